// File: rtl/led_pattern_driver.sv
// led_pattern_driver: synchronises the board switches, divides CLK down to a
// visible step rate and drives an N_LED-wide LED bank as blink, binary count,
// chase or bounce. All outputs come straight from flops.
module led_pattern_driver #(
  parameter int N_LED    = 8,
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       SW,
  output logic [N_LED-1:0] LED,
  output logic             TICK
);

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [N_LED-1:0] PAT_ONE  = N_LED'(1);

  logic             en_meta_q, en_s_q;
  logic [1:0]       sw_meta_q, sw_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step;
  mode_t            mode_q, mode_d, sw_mode;
  logic [N_LED-1:0] pat_q, pat_d, pat_shl, pat_shr;
  logic             dir_q, dir_d;
  logic             tick_q;
  logic             pat_onehot;

  // Two-flop synchronisers for the asynchronous switch inputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      en_meta_q <= 1'b0;
      en_s_q    <= 1'b0;
      sw_meta_q <= 2'b00;
      sw_s_q    <= 2'b00;
    end else begin
      en_meta_q <= EN;
      en_s_q    <= en_meta_q;
      sw_meta_q <= SW;
      sw_s_q    <= sw_meta_q;
    end
  end

  assign sw_mode    = mode_t'(sw_s_q);
  assign pat_shl    = {pat_q[N_LED-2:0], 1'b0};
  assign pat_shr    = {1'b0, pat_q[N_LED-1:1]};
  // Bounce only advances a single lit LED; anything else is re-seeded.
  assign pat_onehot = (pat_q != '0) && ((pat_q & (pat_q - PAT_ONE)) == '0);

  // Prescaler: counts only while enabled, wrapping on the step cycle
  always_comb begin
    step  = en_s_q && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (en_s_q) begin
      cnt_d = step ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Pattern next state: a mode change on a step reloads instead of advancing
  always_comb begin
    mode_d = mode_q;
    pat_d  = pat_q;
    dir_d  = dir_q;
    if (step) begin
      if (sw_mode != mode_q) begin
        mode_d = sw_mode;
        dir_d  = 1'b0;
        pat_d  = (sw_mode == MODE_BLINK) ? '1 : PAT_ONE;
      end else begin
        case (mode_q)
          MODE_BLINK: pat_d = ~pat_q;
          MODE_COUNT: pat_d = pat_q + PAT_ONE;
          MODE_CHASE: pat_d = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
          default: begin
            if (!pat_onehot) begin
              pat_d = PAT_ONE;
              dir_d = 1'b0;
            end else if (!dir_q) begin
              pat_d = pat_shl;
              if (pat_shl[N_LED-1]) dir_d = 1'b1;
            end else begin
              pat_d = pat_shr;
              if (pat_shr[0]) dir_d = 1'b0;
            end
          end
        endcase
      end
    end
  end

  // State and registered outputs; reset wins over a coincident step
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      mode_q <= MODE_BLINK;
      pat_q  <= '0;
      dir_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      tick_q <= step;
    end
  end

  assign LED  = pat_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver with N_LED=4, TICK_DIV=4: fixed vectors and
// scenario sequences, then random switching against a reference model.
module tb_led_pattern_driver;

  localparam int N    = 4;
  localparam int DIV  = 4;
  localparam int MASK = (1 << N) - 1;

  logic         CLK = 1'b0;
  logic         RST;
  logic         EN;
  logic [1:0]   SW;
  logic [N-1:0] LED;
  logic         TICK;

  int checks   = 0;
  int failures = 0;

  led_pattern_driver #(.N_LED(N), .TICK_DIV(DIV)) dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .SW  (SW),
    .LED (LED),
    .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  // Reference model state: what the DUT registers should hold
  int m_en_m, m_en_s, m_sw_m, m_sw_s, m_cnt, m_mode, m_k, m_led, m_tick;

  // Bounce walks 0..N-1..0 with period 2N-2 steps measured from the load.
  function automatic int bounce_led(int k);
    int pos;
    int idx;
    pos = k % (2 * N - 2);
    idx = (pos < N) ? pos : (2 * N - 2 - pos);
    return 1 << idx;
  endfunction

  task automatic model_edge();
    bit stp;
    if (RST) begin
      m_en_m = 0; m_en_s = 0; m_sw_m = 0; m_sw_s = 0;
      m_cnt = 0; m_mode = 0; m_k = 0; m_led = 0; m_tick = 0;
    end else begin
      stp    = (m_en_s == 1) && (m_cnt == DIV - 1);
      m_tick = stp;
      if (m_en_s == 1) m_cnt = (m_cnt + 1) % DIV;
      if (stp) begin
        if (m_sw_s != m_mode) begin
          m_mode = m_sw_s;
          m_k    = 0;
          m_led  = (m_mode == 0) ? MASK : 1;
        end else begin
          m_k = m_k + 1;
          case (m_mode)
            0:       m_led = ~m_led & MASK;
            1:       m_led = (m_led + 1) % (1 << N);
            2:       m_led = 1 << (m_k % N);
            default: m_led = bounce_led(m_k);
          endcase
        end
      end
      m_en_s = m_en_m; m_en_m = EN;
      m_sw_s = m_sw_m; m_sw_m = SW;
    end
  endtask

  // Advance n clock edges; outputs are sampled 1 time unit after each edge
  task automatic run(int n);
    repeat (n) begin
      model_edge();
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset(logic [1:0] sw);
    RST = 1'b1; EN = 1'b1; SW = sw;
    run(3);
    chk("reset_led", {28'd0, LED}, 32'd0);
    chk("reset_tick", {31'd0, TICK}, 32'd0);
    RST = 1'b0;
  endtask

  // First step lands on edge DIV+2 after reset release
  task automatic first_step(string nm, int exp);
    run(DIV + 1);
    chk({nm, "_pre_tick"}, {31'd0, TICK}, 32'd0);
    run(1);
    chk({nm, "_led"}, {28'd0, LED}, exp);
    chk({nm, "_tick"}, {31'd0, TICK}, 32'd1);
  endtask

  task automatic step_chk(string nm, int exp);
    run(DIV - 1);
    chk({nm, "_gap_tick"}, {31'd0, TICK}, 32'd0);
    run(1);
    chk({nm, "_led"}, {28'd0, LED}, exp);
    chk({nm, "_tick"}, {31'd0, TICK}, 32'd1);
  endtask

  typedef struct {
    bit       rst;
    bit       en;
    bit [1:0] sw;
    int       cyc;
    int       led;
    bit       tick;
  } vec_t;

  vec_t tbl[7];

  initial begin
    RST = 1'b1; EN = 1'b0; SW = 2'd0;

    // Reset then blink: 1111 at edge 6, 0000 at 10, 1111 at 14
    tbl = '{
      '{1'b1, 1'b1, 2'd0, 3, 0,    1'b0},
      '{1'b0, 1'b1, 2'd0, 5, 0,    1'b0},
      '{1'b0, 1'b1, 2'd0, 1, MASK, 1'b1},
      '{1'b0, 1'b1, 2'd0, 1, MASK, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2, MASK, 1'b0},
      '{1'b0, 1'b1, 2'd0, 1, 0,    1'b1},
      '{1'b0, 1'b1, 2'd0, 4, MASK, 1'b1}
    };
    for (int i = 0; i < 7; i++) begin
      RST = tbl[i].rst; EN = tbl[i].en; SW = tbl[i].sw;
      run(tbl[i].cyc);
      chk($sformatf("blink_vec%0d_led", i), {28'd0, LED}, tbl[i].led);
      chk($sformatf("blink_vec%0d_tick", i), {31'd0, TICK}, {31'd0, tbl[i].tick});
    end

    // Count: load 0001, then increment through 1111 and wrap to 0000
    do_reset(2'd1);
    first_step("count_s1", 1);
    for (int i = 2; i <= 16; i++) step_chk($sformatf("count_s%0d", i), i % 16);

    // Chase
    do_reset(2'd2);
    first_step("chase_s1", 1);
    step_chk("chase_s2", 4'b0010);
    step_chk("chase_s3", 4'b0100);
    step_chk("chase_s4", 4'b1000);
    step_chk("chase_wrap", 4'b0001);

    // Bounce: end LEDs lit for exactly one step
    do_reset(2'd3);
    first_step("bounce_s1", 1);
    step_chk("bounce_s2", 4'b0010);
    step_chk("bounce_s3", 4'b0100);
    step_chk("bounce_top", 4'b1000);
    step_chk("bounce_down1", 4'b0100);
    step_chk("bounce_down2", 4'b0010);
    step_chk("bounce_bottom", 4'b0001);
    step_chk("bounce_up_again", 4'b0010);

    // Mode change: a one-cycle SW glitch between steps is ignored
    do_reset(2'd1);
    first_step("mc_s1", 1);
    for (int i = 2; i <= 5; i++) step_chk($sformatf("mc_s%0d", i), i);
    SW = 2'd2;
    run(1);
    SW = 2'd1;
    run(DIV - 2);
    chk("mc_glitch_hold", {28'd0, LED}, 32'd5);
    run(1);
    chk("mc_glitch_ignored", {28'd0, LED}, 32'd6);
    chk("mc_glitch_tick", {31'd0, TICK}, 32'd1);
    SW = 2'd2;
    step_chk("mc_load_chase", 4'b0001);

    // Enable freeze: en_s falls with cnt=2, resumes 2 cycles after en_s rises
    do_reset(2'd1);
    first_step("frz_s1", 1);
    EN = 1'b0;
    run(2);
    for (int i = 0; i < 20; i++) begin
      run(1);
      chk($sformatf("frz_low%0d_tick", i), {31'd0, TICK}, 32'd0);
      chk($sformatf("frz_low%0d_led", i), {28'd0, LED}, 32'd1);
    end
    EN = 1'b1;
    run(3);
    chk("frz_resume_early", {31'd0, TICK}, 32'd0);
    run(1);
    chk("frz_resume_tick", {31'd0, TICK}, 32'd1);
    chk("frz_resume_led", {28'd0, LED}, 32'd2);

    // Reset in bounce at 0100 moving down, then reload from 0001 moving up
    do_reset(2'd3);
    first_step("rst_b1", 1);
    step_chk("rst_b2", 4'b0010);
    step_chk("rst_b3", 4'b0100);
    step_chk("rst_b4", 4'b1000);
    step_chk("rst_b5", 4'b0100);
    RST = 1'b1;
    run(1);
    chk("rst_mid_led", {28'd0, LED}, 32'd0);
    chk("rst_mid_tick", {31'd0, TICK}, 32'd0);
    RST = 1'b0;
    first_step("rst_reload", 1);
    step_chk("rst_reload_up", 4'b0010);

    // Random switching against the reference model
    RST = 1'b1; EN = 1'b1; SW = 2'd0;
    run(2);
    RST = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) EN = ~EN;
      if ($urandom_range(14) == 0) SW = 2'($urandom_range(3));
      RST = ($urandom_range(299) == 0);
      run(1);
      chk("rand_led", {28'd0, LED}, m_led);
      chk("rand_tick", {31'd0, TICK}, m_tick);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pattern_driver.md
# led_pattern_driver

Parametrised LED pattern generator for the board-level switch/LED exercises. It synchronises the slide switches and an enable input into the `CLK` domain, divides `CLK` down to a visible step rate, and drives an `N_LED`-wide LED bank in one of four modes: blink, binary count, chase, or bounce. It sits directly between the board switch pins and the LED pins. It replaces the fixed single-LED drive with a registered, reset-clean, multi-channel output.

## Interface
- `N_LED`, 8: number of LED channels; legal range 2..32.
- `TICK_DIV`, 25_000_000: `CLK` cycles per pattern step; legal range ≥2.
- `CNT_W`, $clog2(TICK_DIV): prescaler counter width.

Ports:
- `CLK`  input  1  system clock; one clock domain.
- `RST`  input  1  reset, synchronous to `CLK`, active-high.
- `EN`  input  1  asynchronous switch; 1 runs the pattern, 0 freezes it.
- `SW`  input  2  asynchronous mode switches: 0 blink, 1 count, 2 chase, 3 bounce.
- `LED`  output  N_LED  registered LED drive; 1 = lit.
- `TICK`  output  1  registered one-cycle strobe marking each pattern step.

## Operation
- Synchronisers:
  - `EN` and `SW` each pass through a 2-flop chain to give `en_s` and `sw_s`.
  - Chains reset to 0.
- Prescaler `cnt`, `CNT_W` bits:
  - When `en_s`=1: increments each cycle; at `TICK_DIV-1` it wraps to 0 and raises internal `step`.
  - When `en_s`=0: holds its value, and no `step` is generated.
- State:
  - `mode_q` (2 b).
  - `pat` (`N_LED` b), driven straight onto `LED`.
  - `dir` (0 = up/left, 1 = down/right).
- On `step`, when `sw_s` ≠ `mode_q`, the new mode is loaded and the normal advance does not occur:
  - `mode_q` ← `sw_s`, `dir` ← 0.
  - `pat` ← init value: blink = all ones; count = 1; chase = 1; bounce = 1.
- On `step`, when `sw_s` = `mode_q`, the pattern advances:
  - Blink: `pat` ← ~`pat`.
  - Count: `pat` ← `pat`+1 mod 2^N_LED; all-ones wraps to 0.
  - Chase: rotate left by 1; bit N_LED-1 wraps to bit 0.
  - Bounce, `dir`=0: shift left. If the result has bit N_LED-1 set, `dir` ← 1.
  - Bounce, `dir`=1: shift right. If the result has bit 0 set, `dir` ← 0. The end LED is lit for exactly one step.
  - Bounce recovery: if `pat` is not one-hot on entry, it is replaced by 1 with `dir`=0.
- `SW` changes between steps are not acted on until the next `step`. Only the value of `sw_s` at the `step` cycle matters; intermediate glitches are ignored.
- Reset:
  - `cnt`=0, `mode_q`=0, `pat`=0, `dir`=0, `LED`=0, `TICK`=0.
  - Reset asserted mid-pattern clears everything on the next edge. Reset has priority over `step`.

## Timing
- Input latency: `EN`/`SW` reach `en_s`/`sw_s` 2 edges after they are sampled.
- Update edge: `LED` and `TICK` update on the same edge that consumes `step`. `TICK` is high for exactly one cycle, coincident with the first cycle of the new `LED` value.
- Step period: exactly `TICK_DIV` cycles while `en_s`=1.
- First step after reset release, with `EN`=1 held: `LED` changes at edge `TICK_DIV`+2 after the first non-reset edge.
- Freeze and resume:
  - Dropping `EN` freezes both `cnt` and `LED` 2 cycles later.
  - Re-raising `EN` resumes counting from the frozen `cnt`; no phase reset.
- No combinational path exists from any input to any output.

## Test plan
All scenarios use `N_LED`=4 and `TICK_DIV`=4.

- Reset/blink:
  - Stimulus: hold `RST`=1 for 3 cycles, `EN`=1, `SW`=0.
  - Response: `LED`=0000 and `TICK`=0 during reset. `LED`=1111 with a `TICK` pulse at edge 6 after release. 0000 at edge 10, 1111 at edge 14.
- Count wrap:
  - Stimulus: `SW`=1 from reset.
  - Response: first step loads 0001, then 0010, 0011, …, 1111, then 0000 on the 16th step, with a `TICK` on every step.
- Chase/bounce:
  - Chase (`SW`=2): 0001→0010→0100→1000→0001.
  - Bounce (`SW`=3): 0001→0010→0100→1000→0100→0010→0001→0010.
  - Check that `dir` flips only at the ends.
- Mid-pattern mode change:
  - Stimulus: in count mode at 0101, pulse `SW`=2 for 1 cycle between steps.
  - Response: no change.
  - Stimulus: hold `SW`=2 across a step.
  - Response: `LED`=0001 on that step, not 0110.
- Enable freeze:
  - Stimulus: drop `EN` while `cnt`=2, hold low for 20 cycles, then raise it.
  - Response: no `TICK` and `LED` constant while low. The next step occurs exactly 2 cycles after `en_s` returns high (the 2 remaining counts).
- Reset mid-operation:
  - Stimulus: assert `RST` for 1 cycle in bounce mode at 0100 with `dir`=1.
  - Response: `LED`=0000 and `TICK`=0 on the next edge. After release, the mode is re-entered via the load path, and bounce restarts at 0001 moving up.
